// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal
  } state_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSlt = 4'b0101;
  localparam logic [3:0] AluSll = 4'b0110;
  localparam logic [3:0] AluSrl = 4'b0111;
  localparam logic [3:0] AluSra = 4'b1001;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op and the instruction funct fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = AluAdd;
    bad_funct   = 1'b0;
    unique case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      default: begin
        case (funct3)
          // op5 separates R-type sub from addi, which reuses funct7b5 as imm bit
          3'b000:  alu_control = (funct7b5 & op5) ? AluSub : AluAdd;
          3'b001:  alu_control = AluSll;
          3'b010:  alu_control = AluSlt;
          3'b100:  alu_control = AluXor;
          3'b101:  alu_control = funct7b5 ? AluSra : AluSrl;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: bad_funct = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main Moore control FSM of the multicycle RV32I core plus the branch-taken term.
// Optional feature macro: BRANCH_EXT_EN (adds bne/blt/bge).
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [3:0] dec_alu_control;
  logic       bad_funct;
  logic       taken, bad_branch;
  logic       f_pc_write, f_adr_src, f_mem_write, f_ir_write, f_reg_write, f_illegal;
  logic [1:0] f_result_src, f_alu_src_a, f_alu_src_b, f_imm_src;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (dec_alu_control),
    .bad_funct   (bad_funct)
  );

`ifdef BRANCH_EXT_EN
  always_comb begin
    taken      = 1'b0;
    bad_branch = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt_zero;
      3'b101:  taken = ~lt_zero;
      default: bad_branch = 1'b1;
    endcase
  end
`else
  logic unused_lt_zero;
  assign unused_lt_zero = lt_zero;
  assign taken          = (funct3 == 3'b000) & zero;
  assign bad_branch     = (funct3 != 3'b000);
`endif

  always_comb begin
    case (op)
      OpStore:  f_imm_src = ImmS;
      OpBranch: f_imm_src = ImmB;
      OpJal:    f_imm_src = ImmJ;
      default:  f_imm_src = ImmI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_op       = AluOpAdd;
    f_pc_write   = 1'b0;
    f_adr_src    = 1'b0;
    f_mem_write  = 1'b0;
    f_ir_write   = 1'b0;
    f_reg_write  = 1'b0;
    f_illegal    = 1'b0;
    f_result_src = ResAluOut;
    f_alu_src_a  = SrcAPc;
    f_alu_src_b  = SrcBRs2;
    case (state_q)
      StFetch: begin
        f_alu_src_b  = SrcBFour;
        f_result_src = ResAlu;
        if (mem_ready) begin
          f_ir_write = 1'b1;
          f_pc_write = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        f_alu_src_a = SrcAOldPc;
        f_alu_src_b = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBranch;
          default: begin
            f_illegal = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        f_alu_src_a = SrcARs1;
        f_alu_src_b = SrcBImm;
        state_d     = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        f_adr_src = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        f_result_src = ResData;
        f_reg_write  = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        f_adr_src   = 1'b1;
        f_mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR, StExecI: begin
        alu_op      = AluOpFunct;
        f_alu_src_a = SrcARs1;
        f_alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBRs2;
        f_illegal   = bad_funct;
        state_d     = StAluWb;
      end
      StAluWb: begin
        f_reg_write = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        alu_op      = AluOpSub;
        f_alu_src_a = SrcARs1;
        f_pc_write  = taken;
        f_illegal   = bad_branch;
        state_d     = StFetch;
      end
      StJal: begin
        f_alu_src_a = SrcAOldPc;
        f_alu_src_b = SrcBFour;
        f_pc_write  = 1'b1;
        state_d     = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces every output low immediately, even the FETCH-state decode.
  assign pc_write    = f_pc_write & ~reset;
  assign adr_src     = f_adr_src & ~reset;
  assign mem_write   = f_mem_write & ~reset;
  assign ir_write    = f_ir_write & ~reset;
  assign reg_write   = f_reg_write & ~reset;
  assign illegal     = f_illegal & ~reset;
  assign result_src  = reset ? 2'b00 : f_result_src;
  assign alu_src_a   = reset ? 2'b00 : f_alu_src_a;
  assign alu_src_b   = reset ? 2'b00 : f_alu_src_b;
  assign imm_src     = reset ? 2'b00 : f_imm_src;
  assign alu_control = reset ? 4'b0000 : dec_alu_control;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are queued
// per instruction and compared on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt_zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;
  logic [17:0] got;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  bit          rdy_q[$];
  string       tag_q[$];

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .lt_zero     (lt_zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal};

  task automatic check(input string tag, input logic [17:0] actual, input logic [17:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [17:0] mk(bit pcw, bit adr, bit mw, bit irw, bit rw, logic [1:0] rs,
                                     logic [1:0] a, logic [1:0] b, logic [1:0] imm,
                                     logic [3:0] alu, bit ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_exp(logic [2:0] f3, logic f7, logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0110;
      3'b010:  return 4'b0101;
      3'b100:  return 4'b0100;
      3'b101:  return f7 ? 4'b1001 : 4'b0111;
      3'b110:  return 4'b0011;
      3'b111:  return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic z, logic lt);
`ifdef BRANCH_EXT_EN
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      default: return 1'b0;
    endcase
`else
    return (f3 == 3'b000) && z;
`endif
  endfunction

  function automatic bit br_bad(logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return f3 inside {3'b010, 3'b011, 3'b110, 3'b111};
`else
    return f3 != 3'b000;
`endif
  endfunction

  task automatic push(input bit rdy, input logic [17:0] v, input string tag);
    rdy_q.push_back(rdy);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Entered just after a rising edge; each entry is one clock cycle.
  task automatic drain();
    logic [17:0] e;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      check(tag_q.pop_front(), got, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt, input int fwait, input int mwait);
    logic [1:0] im;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt_zero = lt;
    im = imm_of(o);
    for (int i = 0; i < fwait; i++)
      push(1'b0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 4'b0000, 0), {nm, ".fetch_wait"});
    push(1'b1, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, 4'b0000, 0), {nm, ".fetch"});
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 4'b0000,
                  !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                              7'b1100011})), {nm, ".decode"});
    case (o)
      7'b0000011: begin
        push(1'b0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 0), {nm, ".memadr"});
        for (int i = 0; i < mwait; i++)
          push(1'b0, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".memread_wait"});
        push(1'b1, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".memread"});
        push(1'b1, mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".memwb"});
      end
      7'b0100011: begin
        push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 0), {nm, ".memadr"});
        for (int i = 0; i < mwait; i++)
          push(1'b0, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".memwr_wait"});
        push(1'b1, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".memwr"});
      end
      7'b0110011, 7'b0010011: begin
        push(1'b0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, o[5] ? 2'b00 : 2'b01, im,
                      alu_exp(f3, f7, o[5]), f3 == 3'b011), {nm, ".exec"});
        push(1'b0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".aluwb"});
      end
      7'b1101111: begin
        push(1'b1, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 4'b0000, 0), {nm, ".jal"});
        push(1'b1, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 0), {nm, ".aluwb"});
      end
      7'b1100011:
        push(1'b1, mk(br_taken(f3, z, lt), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 4'b0001,
                      br_bad(f3)), {nm, ".branch"});
      default: ;
    endcase
    drain();
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    zero = 1'b0; lt_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", got, 18'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue("lw", 7'b0000011, 3'b010, 0, 0, 0, 0, 3);
    issue("sw", 7'b0100011, 3'b010, 0, 0, 0, 1, 2);
    issue("add", 7'b0110011, 3'b000, 0, 0, 0, 0, 0);
    issue("sub", 7'b0110011, 3'b000, 1, 0, 0, 0, 0);
    issue("sra", 7'b0110011, 3'b101, 1, 0, 0, 0, 0);
    issue("srl", 7'b0110011, 3'b101, 0, 0, 0, 0, 0);
    issue("sll", 7'b0110011, 3'b001, 0, 0, 0, 0, 0);
    issue("slt", 7'b0110011, 3'b010, 0, 0, 0, 0, 0);
    issue("xor", 7'b0110011, 3'b100, 0, 0, 0, 0, 0);
    issue("or", 7'b0110011, 3'b110, 0, 0, 0, 0, 0);
    issue("and", 7'b0110011, 3'b111, 0, 0, 0, 0, 0);
    issue("r011", 7'b0110011, 3'b011, 0, 0, 0, 0, 0);
    issue("addi_f7", 7'b0010011, 3'b000, 1, 0, 0, 0, 0);
    issue("srai", 7'b0010011, 3'b101, 1, 0, 0, 2, 0);
    issue("beq_t", 7'b1100011, 3'b000, 0, 1, 0, 0, 0);
    issue("beq_nt", 7'b1100011, 3'b000, 0, 0, 0, 0, 0);
    issue("bne_z0", 7'b1100011, 3'b001, 0, 0, 0, 0, 0);
    issue("bne_z1", 7'b1100011, 3'b001, 0, 1, 1, 0, 0);
    issue("blt_lt", 7'b1100011, 3'b100, 0, 0, 1, 0, 0);
    issue("bge_lt", 7'b1100011, 3'b101, 0, 0, 1, 0, 0);
    issue("bge_ge", 7'b1100011, 3'b101, 0, 1, 0, 0, 0);
    issue("b010", 7'b1100011, 3'b010, 0, 1, 0, 0, 0);
    issue("jal", 7'b1101111, 3'b000, 0, 0, 0, 0, 0);
    issue("op0", 7'b0000000, 3'b000, 0, 0, 0, 0, 0);
    issue("addi", 7'b0010011, 3'b000, 0, 0, 0, 0, 0);

    // Stall a store in MEMWRITE, then hit reset asynchronously mid-cycle.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    push(1'b1, mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000, 0), "swr.fetch");
    push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0000, 0), "swr.decode");
    push(1'b0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000, 0), "swr.memadr");
    push(1'b0, mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 0), "swr.memwr_wait");
    drain();
    check("swr.still_writing", {17'h0, mem_write}, 18'h1);
    #2 reset = 1'b1;
    #1 check("swr.reset_drop", got, 18'h0);
    #2 reset = 1'b0;
    mem_ready = 1'b0;
    #1 check("swr.after_reset_fetch", got,
             mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000, 0));
    @(posedge clk); #1;
    issue("lw_after", 7'b0000011, 3'b010, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
